// File: rtl/noc_ni_test_if.sv
// Core/router handshake bundle for the network-interface test block.
// The master side drives the DUT inputs; the slave side is the NI itself.
interface noc_ni_test_if #(
    parameter int RSIZE = 16
);
    logic             core_write_en;
    logic             core_read_en;
    logic [RSIZE-1:0] core_wdata;
    logic [RSIZE-1:0] core_waddr;
    logic             core_wfull;
    logic [RSIZE-1:0] core_rdata;
    logic             core_rempty;
    logic             ni_wfull;
    logic [RSIZE-1:0] ni_wdata;
    logic [RSIZE-1:0] ni_waddr;
    logic             ni_write_en;
    logic             ni_rempty;
    logic [RSIZE-1:0] ni_rdata;
    logic             ni_read_en;

    modport master (
        output core_write_en, core_read_en, core_wdata, core_waddr,
        output ni_wfull, ni_rempty, ni_rdata,
        input  core_wfull, core_rdata, core_rempty,
        input  ni_wdata, ni_waddr, ni_write_en, ni_read_en
    );

    modport slave (
        input  core_write_en, core_read_en, core_wdata, core_waddr,
        input  ni_wfull, ni_rempty, ni_rdata,
        output core_wfull, core_rdata, core_rempty,
        output ni_wdata, ni_waddr, ni_write_en, ni_read_en
    );
endinterface

// File: rtl/noc_ni_test.sv
// Network interface: TX FIFO of {addr,data} core writes drained to the router,
// RX FIFO of inbound router words read by the core. Both FIFOs are show-ahead.
module noc_ni_test #(
    parameter int ADDRSIZE = 5,
    parameter int MSB_SLOT = 5
) (
    input logic           clk,
    input logic           reset,
    noc_ni_test_if.slave  bus
);
    localparam int DSIZE = 1 << MSB_SLOT;
    localparam int RSIZE = 1 << (MSB_SLOT - 1);
    localparam int DEPTH = 1 << ADDRSIZE;

    localparam logic [ADDRSIZE:0]   CNT_FULL = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0]   CNT_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE-1:0] PTR_ONE  = {{(ADDRSIZE-1){1'b0}}, 1'b1};

    logic [DSIZE-1:0]    tx_mem [DEPTH];
    logic [ADDRSIZE-1:0] tx_wptr, tx_rptr;
    logic [ADDRSIZE:0]   tx_count;
    logic                tx_full, tx_empty, tx_push, tx_pop;
    logic [DSIZE-1:0]    tx_head;

    logic [RSIZE-1:0]    rx_mem [DEPTH];
    logic [ADDRSIZE-1:0] rx_wptr, rx_rptr;
    logic [ADDRSIZE:0]   rx_count;
    logic                rx_full, rx_empty, rx_push, rx_pop;

    always_comb begin
        tx_full  = (tx_count == CNT_FULL);
        tx_empty = (tx_count == '0);
        rx_full  = (rx_count == CNT_FULL);
        rx_empty = (rx_count == '0);

        // Push is gated by the current full flag and pop by the current empty
        // flag, so a same-cycle pop never makes room for a push (and vice versa).
        tx_push = bus.core_write_en && !tx_full;
        tx_pop  = !tx_empty && !bus.ni_wfull;
        rx_push = reset && !bus.ni_rempty && !rx_full;
        rx_pop  = bus.core_read_en && !rx_empty;

        tx_head = tx_mem[tx_rptr];
    end

    always_comb begin
        bus.core_wfull  = tx_full;
        bus.core_rempty = rx_empty;
        bus.core_rdata  = rx_empty ? '0 : rx_mem[rx_rptr];
        bus.ni_write_en = tx_pop;
        bus.ni_read_en  = rx_push;
        bus.ni_waddr    = tx_empty ? '0 : tx_head[DSIZE-1:RSIZE];
        bus.ni_wdata    = tx_empty ? '0 : tx_head[RSIZE-1:0];
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= {bus.core_waddr, bus.core_wdata};
        if (rx_push) rx_mem[rx_wptr] <= bus.ni_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_ONE;
                2'b01:   tx_count <= tx_count - CNT_ONE;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CNT_ONE;
                2'b01:   rx_count <= rx_count - CNT_ONE;
                default: rx_count <= rx_count;
            endcase
        end
    end
endmodule

// File: tb/tb_noc_ni_test.sv
// Scoreboard bench for noc_ni_test: directed test-plan scenarios plus random
// traffic, checked against queue-based TX/RX reference FIFOs.
module tb_noc_ni_test;
    logic clk;
    logic reset;

    noc_ni_test_if #(.RSIZE(16)) bus ();

    noc_ni_test #(.ADDRSIZE(5), .MSB_SLOT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] txq[$];
    logic [15:0] rxq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference FIFOs: entries are accepted only when the queue had room
    // before the edge, and removed only when it held something before the edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txq.delete();
            rxq.delete();
        end else begin
            automatic bit tx_in  = bus.core_write_en && (txq.size() < 32);
            automatic bit tx_out = (txq.size() != 0) && !bus.ni_wfull;
            automatic bit rx_in  = !bus.ni_rempty && (rxq.size() < 32);
            automatic bit rx_out = bus.core_read_en && (rxq.size() != 0);
            if (tx_out) void'(txq.pop_front());
            if (tx_in)  txq.push_back({bus.core_waddr, bus.core_wdata});
            if (rx_out) void'(rxq.pop_front());
            if (rx_in)  rxq.push_back(bus.ni_rdata);
        end
    end

    always @(negedge clk) begin
        check("core_wfull",  {31'd0, bus.core_wfull},  {31'd0, txq.size() == 32});
        check("core_rempty", {31'd0, bus.core_rempty}, {31'd0, rxq.size() == 0});
        check("ni_write_en", {31'd0, bus.ni_write_en},
              {31'd0, (txq.size() != 0) && !bus.ni_wfull});
        check("ni_read_en",  {31'd0, bus.ni_read_en},
              {31'd0, reset && !bus.ni_rempty && (rxq.size() != 32)});
        check("tx_head", {bus.ni_waddr, bus.ni_wdata}, (txq.size() != 0) ? txq[0] : 32'd0);
        check("rx_head", {16'd0, bus.core_rdata}, {16'd0, (rxq.size() != 0) ? rxq[0] : 16'd0});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b0;
        bus.core_write_en  = 1'b1;
        bus.core_read_en   = 1'b0;
        bus.core_wdata     = 16'h1234;
        bus.core_waddr     = 16'h5678;
        bus.ni_wfull       = 1'b0;
        bus.ni_rempty      = 1'b0;
        bus.ni_rdata       = 16'h7777;

        // Reset held with traffic offered on both sides
        repeat (3) begin
            @(negedge clk);
            check("rst_ni_read_en",  {31'd0, bus.ni_read_en},  32'd0);
            check("rst_core_rempty", {31'd0, bus.core_rempty}, 32'd1);
            check("rst_core_wfull",  {31'd0, bus.core_wfull},  32'd0);
            check("rst_ni_write_en", {31'd0, bus.ni_write_en}, 32'd0);
            check("rst_ni_wdata",    {16'd0, bus.ni_wdata},    32'd0);
        end
        step();
        bus.core_write_en = 1'b0;
        bus.ni_rempty     = 1'b1;
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_nothing_stored", {31'd0, bus.ni_write_en}, 32'd0);

        // Single TX transfer
        step();
        bus.core_waddr = 16'hBCCB; bus.core_wdata = 16'hABBA; bus.core_write_en = 1'b1;
        step();
        bus.core_write_en = 1'b0;
        @(negedge clk);
        check("tx1_write_en", {31'd0, bus.ni_write_en}, 32'd1);
        check("tx1_head", {bus.ni_waddr, bus.ni_wdata}, 32'hBCCB_ABBA);
        @(negedge clk);
        check("tx1_after_en",   {31'd0, bus.ni_write_en}, 32'd0);
        check("tx1_after_head", {bus.ni_waddr, bus.ni_wdata}, 32'd0);

        // RX capture and core read
        step();
        bus.ni_rempty = 1'b0; bus.ni_rdata = 16'hAAAA;
        @(negedge clk);
        check("rx1_read_en", {31'd0, bus.ni_read_en}, 32'd1);
        step();
        bus.ni_rempty = 1'b1;
        @(negedge clk);
        check("rx1_rempty", {31'd0, bus.core_rempty}, 32'd0);
        check("rx1_rdata",  {16'd0, bus.core_rdata},  32'h0000_AAAA);
        step();
        bus.core_read_en = 1'b1;
        step();
        bus.core_read_en = 1'b0;
        @(negedge clk);
        check("rx1_after_read", {31'd0, bus.core_rempty}, 32'd1);

        // Backpressure holds the head stable
        step();
        bus.ni_wfull = 1'b1;
        bus.core_waddr = 16'hBABA; bus.core_wdata = 16'hCCCC; bus.core_write_en = 1'b1;
        step();
        bus.core_write_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_write_en", {31'd0, bus.ni_write_en}, 32'd0);
            check("bp_head", {bus.ni_waddr, bus.ni_wdata}, 32'hBABA_CCCC);
        end
        step();
        bus.ni_wfull = 1'b0;
        @(negedge clk);
        check("bp_release_pulse", {31'd0, bus.ni_write_en}, 32'd1);
        @(negedge clk);
        check("bp_single_pulse", {31'd0, bus.ni_write_en}, 32'd0);

        // Fill to 33, drain 32 in order; twice to wrap the pointers
        for (int round = 0; round < 2; round++) begin
            step();
            bus.ni_wfull = 1'b1;
            for (int i = 0; i <= 32; i++) begin
                bus.core_write_en = 1'b1;
                bus.core_waddr    = 16'(16'h4000 + i);
                bus.core_wdata    = 16'(i);
                if (i == 32) begin
                    @(negedge clk);
                    check("full_after_32", {31'd0, bus.core_wfull}, 32'd1);
                end
                step();
            end
            bus.core_write_en = 1'b0;
            @(negedge clk);
            check("full_hold", {31'd0, bus.core_wfull}, 32'd1);
            step();
            bus.ni_wfull = 1'b0;
            for (int k = 0; k < 32; k++) begin
                @(negedge clk);
                check("drain_en",   {31'd0, bus.ni_write_en}, 32'd1);
                check("drain_data", {16'd0, bus.ni_wdata}, 32'(k));
                if (k == 1) check("wfull_fell", {31'd0, bus.core_wfull}, 32'd0);
            end
            @(negedge clk);
            check("drain_done", {31'd0, bus.ni_write_en}, 32'd0);
        end

        // Random traffic, both directions concurrently
        for (int c = 0; c < 600; c++) begin
            step();
            bus.core_write_en = 1'($urandom_range(0, 1));
            bus.core_read_en  = ($urandom_range(0, 3) == 0);
            bus.core_waddr    = 16'($urandom);
            bus.core_wdata    = 16'($urandom);
            bus.ni_wfull      = ($urandom_range(0, 2) == 0);
            bus.ni_rempty     = 1'($urandom_range(0, 1));
            bus.ni_rdata      = 16'($urandom);
        end
        step();
        bus.core_write_en = 1'b0; bus.ni_rempty = 1'b1;
        bus.ni_wfull = 1'b0;      bus.core_read_en = 1'b1;
        repeat (40) step();
        bus.core_read_en = 1'b0;

        // Mid-operation asynchronous reset with 5 TX and 3 RX entries buffered
        bus.ni_wfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.core_write_en = 1'b1;
            bus.core_waddr    = 16'(16'h0100 + i);
            bus.core_wdata    = 16'(16'h0200 + i);
            bus.ni_rempty     = (i >= 3);
            bus.ni_rdata      = 16'(16'h0050 + i);
        end
        step();
        bus.core_write_en = 1'b0; bus.ni_rempty = 1'b1;
        @(negedge clk);
        check("pre_rst_rempty", {31'd0, bus.core_rempty}, 32'd0);
        check("pre_rst_head", {bus.ni_waddr, bus.ni_wdata}, 32'h0100_0200);
        step();
        bus.ni_wfull = 1'b0;
        #2;
        check("pre_rst_write_en", {31'd0, bus.ni_write_en}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_rempty",   {31'd0, bus.core_rempty}, 32'd1);
        check("mid_rst_write_en", {31'd0, bus.ni_write_en}, 32'd0);
        check("mid_rst_wdata",    {16'd0, bus.ni_wdata},    32'd0);
        check("mid_rst_waddr",    {16'd0, bus.ni_waddr},    32'd0);
        step();
        #1 reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("post_rst_empty", {31'd0, bus.ni_write_en}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
